// File: rtl/pixel_row_receiver.sv
// Receives one-hot-selected pixel rows into a 2-deep FIFO and streams them as 8-bit pixels.
// Optional frame checksum outputs are enabled by defining PIXEL_ROW_RECEIVER_CHECKSUM_EN.
module pixel_row_receiver #(
    parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
    parameter int unsigned SAMPLE_DELAY       = 2,
    localparam int unsigned RowIdxW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]  read,
    input  logic [8*PIXEL_ARRAY_WIDTH-1:0] row_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [7:0]                     m_data,
    output logic [RowIdxW-1:0]             m_row,
    output logic                           m_sof,
    output logic                           m_eol,
    output logic                           m_eof,
    output logic                           overflow,
`ifdef PIXEL_ROW_RECEIVER_CHECKSUM_EN
    output logic [15:0]                    chk_sum,
    output logic                           chk_valid,
`endif
    output logic                           protocol_err
);

    localparam int unsigned ColW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
    localparam int unsigned CntW = $clog2(SAMPLE_DELAY + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

    state_e                          state_q, state_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0]   read_lat_q, read_lat_d;
    logic [RowIdxW-1:0]              idx_lat_q, idx_lat_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [RowIdxW-1:0]              read_idx;
    logic                            sample;
    logic                            perr_set;

    always_comb begin
        read_idx = '0;
        for (int i = 0; i < int'(PIXEL_ARRAY_HEIGHT); i++) begin
            if (read[i]) read_idx = RowIdxW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        read_lat_d = read_lat_q;
        idx_lat_d  = idx_lat_q;
        cnt_d      = cnt_q;
        sample     = 1'b0;
        perr_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ($onehot(read)) begin
                    read_lat_d = read;
                    idx_lat_d  = read_idx;
                    cnt_d      = '0;
                    state_d    = StSettle;
                end else if (read != '0) begin
                    perr_set = 1'b1;
                end
            end
            StSettle: begin
                if (read != read_lat_q) begin
                    perr_set = 1'b1;
                    state_d  = StIdle;
                end else if (cnt_q == CntW'(SAMPLE_DELAY - 1)) begin
                    sample  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // A held select yields one row; only a change re-arms the tracker.
                if (read != read_lat_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            read_lat_q <= '0;
            idx_lat_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            read_lat_q <= read_lat_d;
            idx_lat_q  <= idx_lat_d;
            cnt_q      <= cnt_d;
        end
    end

    logic [8*PIXEL_ARRAY_WIDTH-1:0] fifo_data_q [2];
    logic [RowIdxW-1:0]             fifo_idx_q  [2];
    logic                           rd_ptr_q, wr_ptr_q;
    logic [1:0]                     count_q, count_d;
    logic [ColW-1:0]                col_q;
    logic                           overflow_q, perr_q;
    logic                           xfer, pop, push, full;

    assign xfer = m_valid && m_ready;
    assign pop  = xfer && m_eol;
    assign full = (count_q == 2'd2);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = sample && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            col_q      <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= row_data;
                fifo_idx_q[wr_ptr_q]  <= idx_lat_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (xfer) col_q <= m_eol ? '0 : col_q + ColW'(1);
            count_q <= count_d;
            if (sample && full && !pop) overflow_q <= 1'b1;
            if (perr_set) perr_q <= 1'b1;
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < int'(PIXEL_ARRAY_WIDTH); i++) begin
            if (col_q == ColW'(i)) m_data = fifo_data_q[rd_ptr_q][8*i +: 8];
        end
    end

    assign m_valid      = (count_q != 2'd0);
    assign m_row        = fifo_idx_q[rd_ptr_q];
    assign m_eol        = (col_q == ColW'(PIXEL_ARRAY_WIDTH - 1));
    assign m_sof        = (col_q == '0) && (m_row == '0);
    assign m_eof        = m_eol && (m_row == RowIdxW'(PIXEL_ARRAY_HEIGHT - 1));
    assign overflow     = overflow_q;
    assign protocol_err = perr_q;

`ifdef PIXEL_ROW_RECEIVER_CHECKSUM_EN
    logic [15:0] acc_q, chk_sum_q, acc_sum;
    logic        chk_valid_q;

    assign acc_sum = (m_sof ? 16'd0 : acc_q) + {8'd0, m_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            chk_sum_q   <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            chk_valid_q <= 1'b0;
            if (xfer) begin
                acc_q <= acc_sum;
                if (m_eof) begin
                    chk_sum_q   <= acc_sum;
                    chk_valid_q <= 1'b1;
                end
            end
        end
    end

    assign chk_sum   = chk_sum_q;
    assign chk_valid = chk_valid_q;
`else
    // Checksum disabled: no accumulator is built.
`endif

endmodule
